// File: rtl/mux_pkg.sv
// Shared helpers for the N:1 pipelined mux.
// clog2 / sel_width size the channel-index buses. sel_width never returns
// less than 1, so a select port always exists even for tiny N.
package mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Width of a channel index for n channels (chan_idx_t-style width helper).
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_pipe_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// Searches req upward from ptr, wrapping at N, and grants the first set bit.
// Ports:
//   req         in  N      request per channel
//   ptr         in  SEL_W  search start (always < N)
//   grant       out SEL_W  granted channel index (0 when none)
//   grant_valid out 1      some channel was granted
module rr_arbiter import mux_pkg::*; #(
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  // Walk the offsets from far to near so the nearest requester is written
  // last and therefore wins; no early-exit flag needed.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-to-1 channel mux with one registered output stage and
// valid/ready handshakes on every channel and on the output.
// Build option: define MUX_NX1_PIPE_RR_EN for round-robin arbitration over
// in_valid (sel ignored); otherwise sel picks the channel statically.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   in_data  N*WIDTH channel i at [i*WIDTH +: WIDTH]
//   in_valid N       per-channel valid
//   in_ready N       per-channel ready (only the granted channel)
//   sel      SEL_W   static channel select
//   out_data WIDTH   registered word
//   out_valid        out_data holds an untaken word
//   out_ready        downstream takes out_data
//   out_chan SEL_W   channel that supplied out_data
module mux_nx1_pipe import mux_pkg::*; #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_chan
);

  logic [N-1:0][WIDTH-1:0] in_arr;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [SEL_W-1:0]        out_chan_q, out_chan_d;
  logic                    can_accept;
  logic                    grant_vld;
  logic [SEL_W-1:0]        grant_idx;
  logic [WIDTH-1:0]        grant_data;
  logic                    xfer;

  assign in_arr     = in_data;
  assign can_accept = !out_valid_q || out_ready;

`ifdef MUX_NX1_PIPE_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             unused_sel;

  assign unused_sel = ^sel;

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant       (grant_idx),
    .grant_valid (grant_vld)
  );

  // Pointer moves just past the channel that actually transferred.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Out-of-range select grants nothing; ready never looks at in_valid here.
  assign grant_vld = int'(sel) < N;
  assign grant_idx = sel;
`endif

  // rst_n gates ready so nothing looks acceptable while reset is held.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int g = 0; g < N; g++) begin
      if (grant_idx == SEL_W'(g)) begin
        in_ready[g] = rst_n && can_accept && grant_vld;
        grant_data  = in_arr[g];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Load on transfer; otherwise a taken word just drops valid and the
  // data/chan registers keep their last contents.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: a 4-channel instance driven cycle by cycle against
// a reference model with a scoreboard queue, plus a 6-channel instance for
// out-of-range select behaviour. Round-robin scenarios run when
// MUX_NX1_PIPE_RR_EN is defined.
module tb_mux_nx1_pipe;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
  } sb_t;

  logic        clk, rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  sel, out_chan;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;

  logic [47:0] in_data6;
  logic [5:0]  in_valid6, in_ready6;
  logic [2:0]  sel6, out_chan6;
  logic [7:0]  out_data6;
  logic        out_valid6, out_ready6;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_chan;
  logic [1:0] m_ptr;
  sb_t        sbq[$];

  mux_nx1_pipe #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
  );

  mux_nx1_pipe #(.WIDTH(8), .N(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .sel(sel6), .out_data(out_data6), .out_valid(out_valid6),
    .out_ready(out_ready6), .out_chan(out_chan6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_ptr   = '0;
    sbq.delete();
  endtask

  // One clock of the 4-channel DUT: check ready before the edge, check the
  // output register after it. Entered and left just after a falling edge.
  task automatic cycle(input string tag);
    logic       gv, xf;
    logic [1:0] g;
    logic [3:0] er;
    sb_t        e;
    int         p;
    gv = 1'b0;
    g  = '0;
`ifdef MUX_NX1_PIPE_RR_EN
    for (int k = 3; k >= 0; k--) begin
      p = (int'(m_ptr) + k) % 4;
      if (in_valid[p]) begin gv = 1'b1; g = 2'(p); end
    end
`else
    p  = 0;
    gv = 1'b1;
    g  = sel;
`endif
    er = (gv && (!m_valid || out_ready)) ? (4'b0001 << g) : 4'b0000;
    #1;
    checks++;
    if (in_ready !== er) begin
      errors++;
      $display("FAIL %s in_ready: got %b exp %b", tag, in_ready, er);
    end
    xf = |(er & in_valid);
    if (xf) sbq.push_back('{d: in_data[g*8 +: 8], c: g});
    @(posedge clk);
    #1;
    if (xf) begin
      e       = sbq.pop_front();
      m_valid = 1'b1;
      m_data  = e.d;
      m_chan  = e.c;
      m_ptr   = (g == 2'd3) ? 2'd0 : g + 2'd1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL %s out_valid: got %b exp %b", tag, out_valid, m_valid);
    end
    checks++;
    if (out_data !== m_data) begin
      errors++;
      $display("FAIL %s out_data: got %0d exp %0d", tag, out_data, m_data);
    end
    checks++;
    if (out_chan !== m_chan) begin
      errors++;
      $display("FAIL %s out_chan: got %0d exp %0d", tag, out_chan, m_chan);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 4'hf;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset outputs: got v=%b d=%0d c=%0d exp 0 0 0", out_valid, out_data, out_chan);
    end
    checks++;
    if (in_ready !== 4'b0000 || in_ready6 !== 6'b0) begin
      errors++;
      $display("FAIL reset in_ready: got %b/%b exp 0", in_ready, in_ready6);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset no_xfer: got out_valid %b exp 0", out_valid);
    end
    @(negedge clk);
    in_valid = 4'h0;
    rst_n    = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    in_data   = {8'd4, 8'd3, 8'd2, 8'd1};
    in_valid  = 4'hf;
    sel       = 2'd2;
    out_ready = 1'b1;
    cycle("basic");
    checks++;
    if (out_data !== 8'd3 || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL basic const: got d=%0d c=%0d exp 3 2", out_data, out_chan);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    sel       = 2'd0;
    for (int i = 0; i < 3; i++) cycle("bp_hold");
    checks++;
    if (out_data !== 8'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp const: got d=%0d v=%b exp 3 1", out_data, out_valid);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    checks++;
    if (out_data !== 8'd1 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL bp release const: got d=%0d c=%0d exp 1 0", out_data, out_chan);
    end
  endtask

  task automatic test_drain();
    in_valid = 4'h0;
    cycle("drain");
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd1) begin
      errors++;
      $display("FAIL drain const: got v=%b d=%0d exp 0 1", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("random");
    end
  endtask

  task automatic test_async_reset();
    in_data   = {8'd40, 8'd30, 8'd20, 8'd10};
    in_valid  = 4'hf;
    sel       = 2'd1;
    out_ready = 1'b0;
    cycle("ar_load");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%0d c=%0d exp 0 0 0", out_valid, out_data, out_chan);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset in_ready: got %b exp 0000", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    in_valid = 4'h0;
  endtask

  task automatic test_sel_range();
    for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'(i + 10);
    in_valid6  = 6'h3f;
    sel6       = 3'd5;
    out_ready6 = 1'b1;
    #1;
    checks++;
    if (in_ready6 !== 6'b100000) begin
      errors++;
      $display("FAIL sel5 in_ready: got %b exp 100000", in_ready6);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid6 !== 1'b1 || out_data6 !== 8'd15 || out_chan6 !== 3'd5) begin
      errors++;
      $display("FAIL sel5 out: got v=%b d=%0d c=%0d exp 1 15 5", out_valid6, out_data6, out_chan6);
    end
    @(negedge clk);
    sel6 = 3'd7;
    #1;
    checks++;
    if (in_ready6 !== 6'b0) begin
      errors++;
      $display("FAIL sel7 in_ready: got %b exp 000000", in_ready6);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid6 !== 1'b0 || out_data6 !== 8'd15) begin
      errors++;
      $display("FAIL sel7 drain: got v=%b d=%0d exp 0 15", out_valid6, out_data6);
    end
    @(negedge clk);
    in_valid6 = 6'h0;
  endtask

  task automatic test_rr();
    logic [1:0] seq_a [5];
    logic [1:0] seq_b [4];
    seq_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    seq_b = '{2'd1, 2'd3, 2'd1, 2'd3};
    in_data   = {8'd4, 8'd3, 8'd2, 8'd1};
    in_valid  = 4'hf;
    out_ready = 1'b1;
    sel       = 2'd2;
    for (int i = 0; i < 5; i++) begin
      cycle("rr_all");
      checks++;
      if (out_chan !== seq_a[i]) begin
        errors++;
        $display("FAIL rr_all seq[%0d]: got %0d exp %0d", i, out_chan, seq_a[i]);
      end
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle("rr_13");
      checks++;
      if (out_chan !== seq_b[i]) begin
        errors++;
        $display("FAIL rr_13 seq[%0d]: got %0d exp %0d", i, out_chan, seq_b[i]);
      end
    end
    in_valid = 4'h0;
    for (int i = 0; i < 3; i++) cycle("rr_idle");
    for (int i = 0; i < 40; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rr_random");
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    sel        = '0;
    out_ready  = 1'b0;
    in_data6   = '0;
    in_valid6  = '0;
    sel6       = '0;
    out_ready6 = 1'b0;
    model_reset();
    test_reset();
`ifdef MUX_NX1_PIPE_RR_EN
    test_rr();
    test_async_reset();
`else
    test_basic();
    test_backpressure();
    test_drain();
    test_random();
    test_async_reset();
    test_sel_range();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
